song_sequencer: RTL and testbench

Parametrised successor to the lab-4 song reader. It steps through one of NUM_SONGS note sequences stored in an external synchronous song ROM. Each note is presented to the note player as a (note, duration) pair with a one-cycle new_note strobe, and the sequencer waits for note_done before advancing. Over the fixed 2-bit, fixed-length reader, it adds pause/resume, an abort-and-restart on song change, loop mode and an optional early end-of-song marker.

---
 rtl/song_sequencer.sv | 156 +++++++++++++++
 tb/tb_song_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// Song ROM sequencer: fetches {note, duration} words and strobes them to a note player.
// Define SONG_SEQ_EOS_MARKER_EN to treat a zero-duration word as an early end-of-song marker.
module song_sequencer #(
  parameter  int unsigned NUM_SONGS      = 4,
  parameter  int unsigned NOTES_PER_SONG = 32,
  parameter  int unsigned NOTE_W         = 6,
  parameter  int unsigned DUR_W          = 6,
  localparam int unsigned SONG_W         = $clog2(NUM_SONGS),
  localparam int unsigned IDX_W          = $clog2(NOTES_PER_SONG),
  localparam int unsigned ROM_AW         = SONG_W + IDX_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play,
  input  logic                      loop,
  input  logic [SONG_W-1:0]         song,
  input  logic                      note_done,
  output logic [ROM_AW-1:0]         rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]   rom_data,
  output logic [NOTE_W-1:0]         note,
  output logic [DUR_W-1:0]          duration,
  output logic                      new_note,
  output logic                      song_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    EMIT  = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOTES_PER_SONG - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SONG_W-1:0]   song_q, song_d;
  logic                armed_q, armed_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic                new_note_q, new_note_d;
  logic                song_done_q, song_done_d;

  logic [DUR_W-1:0]    rom_dur;
  logic [NOTE_W-1:0]   rom_note;

  assign rom_dur  = rom_data[DUR_W-1:0];
  assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    song_d  = song_q;
    armed_d = armed_q;
    note_d  = note_q;
    dur_d   = dur_q;

    if (!play) begin
      armed_d = 1'b1;
    end else if (state_q != IDLE && song != song_q) begin
      song_d  = song;
      idx_d   = '0;
      state_d = FETCH;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (armed_q || song != song_q) begin
            song_d  = song;
            idx_d   = '0;
            state_d = FETCH;
          end
        end
        FETCH: state_d = LOAD;
        LOAD: begin
`ifdef SONG_SEQ_EOS_MARKER_EN
          if (rom_dur == '0) begin
            state_d = DONE;
          end else begin
            note_d  = rom_note;
            dur_d   = rom_dur;
            state_d = EMIT;
          end
`else
          note_d  = rom_note;
          dur_d   = rom_dur;
          state_d = EMIT;
`endif
        end
        // EMIT/DONE leave only after their strobe was visible, so a pause re-fires it
        EMIT: begin
          if (new_note_q) state_d = WAIT;
        end
        WAIT: begin
          if (note_done) begin
            if (idx_q != LAST_IDX) begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = FETCH;
            end else begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (song_done_q) begin
            if (loop) begin
              idx_d   = '0;
              state_d = FETCH;
            end else begin
              armed_d = 1'b0;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    rom_addr_d  = {song_d, idx_d};
    new_note_d  = play && (state_d == EMIT);
    song_done_d = play && (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      song_q      <= '0;
      armed_q     <= 1'b1;
      note_q      <= '0;
      dur_q       <= '0;
      rom_addr_q  <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      song_q      <= song_d;
      armed_q     <= armed_d;
      note_q      <= note_d;
      dur_q       <= dur_d;
      rom_addr_q  <= rom_addr_d;
      new_note_q  <= new_note_d;
      song_done_q <= song_done_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign note      = note_q;
  assign duration  = dur_q;
  assign new_note  = new_note_q;
  assign song_done = song_done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a behavioural synchronous song ROM.
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        play;
  logic        loop;
  logic [1:0]  song;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        new_note;
  logic        song_done;

  int errors = 0;
  int checks = 0;

  song_sequencer #(
    .NUM_SONGS      (4),
    .NOTES_PER_SONG (32),
    .NOTE_W         (6),
    .DUR_W          (6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .play      (play),
    .loop      (loop),
    .song      (song),
    .note_done (note_done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .note      (note),
    .duration  (duration),
    .new_note  (new_note),
    .song_done (song_done)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_word(input logic [6:0] a);
    int s;
    int i;
    logic [5:0] n;
    logic [5:0] d;
    s = int'(a[6:5]);
    i = int'(a[4:0]);
    n = 6'(s * 8 + i);
    d = 6'(i + 1);
`ifdef SONG_SEQ_EOS_MARKER_EN
    if (s == 1 && i == 7) d = 6'd0;
`endif
    return {n, d};
  endfunction

  always @(posedge clk) rom_data <= rom_word(rom_addr);

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0; play = 1'b0; loop = 1'b0; note_done = 1'b0; song = 2'd0;
    step(); step();
    reset = 1'b1;
  endtask

  task automatic wait_nn(input int budget, output bit got, output int sd_seen, output int cycles);
    got = 1'b0; sd_seen = 0; cycles = 0;
    for (int c = 0; c < budget; c++) begin
      step();
      cycles++;
      if (song_done) sd_seen++;
      if (new_note) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; play = 1'b1; loop = 1'b0; note_done = 1'b0; song = 2'd0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({rom_addr, note, duration, new_note, song_done} !== 21'd0) begin
        errors++;
        $display("FAIL reset_outputs: got addr=%0d note=%0d dur=%0d nn=%b sd=%b, expected all 0",
                 rom_addr, note, duration, new_note, song_done);
      end
    end
    reset = 1'b1;
    step(); step();
    checks++;
    if (new_note !== 1'b0) begin
      errors++;
      $display("FAIL start_early: new_note=%b after 2nd edge, expected 0", new_note);
    end
    step();
    checks++;
    if (new_note !== 1'b1 || note !== 6'd0 || duration !== 6'd1) begin
      errors++;
      $display("FAIL start_first_note: nn=%b note=%0d dur=%0d, expected nn=1 note=0 dur=1",
               new_note, note, duration);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (duration !== 6'd0 || new_note !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: dur=%0d nn=%b, expected 0 0 without a clock edge", duration, new_note);
    end
    #1;
  endtask

  task automatic test_full_song();
    int k = 0, prev = 0, cyc = 0, sd = 0, sd_cyc = 0, extra = 0, sdx, cycles;
    bit got;
    do_reset();
    song = 2'd0; note_done = 1'b1; loop = 1'b0; play = 1'b1;
    for (int c = 0; c < 200; c++) begin
      step();
      cyc++;
      if (new_note) begin
        checks++;
        if (note !== 6'(k)) begin
          errors++;
          $display("FAIL full_note[%0d]: got %0d expected %0d", k, note, k);
        end
        if (k > 0) begin
          checks++;
          if (cyc - prev != 4) begin
            errors++;
            $display("FAIL full_spacing[%0d]: got %0d cycles expected 4", k, cyc - prev);
          end
        end
        prev = cyc;
        k++;
      end
      if (song_done) begin
        sd++;
        sd_cyc = cyc;
      end
    end
    checks++;
    if (k != 32) begin
      errors++;
      $display("FAIL full_count: got %0d notes expected 32", k);
    end
    checks++;
    if (sd != 1 || sd_cyc != prev + 2) begin
      errors++;
      $display("FAIL full_song_done: got %0d pulses at +%0d expected 1 at +2", sd, sd_cyc - prev);
    end
    for (int c = 0; c < 20; c++) begin
      step();
      if (new_note || song_done) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL full_no_replay: got %0d strobes while play held, expected 0", extra);
    end
    play = 1'b0;
    step();
    play = 1'b1;
    wait_nn(10, got, sdx, cycles);
    checks++;
    if (!got || note !== 6'd0 || cycles != 3) begin
      errors++;
      $display("FAIL full_rearm: got=%b note=%0d lat=%0d expected 1 0 3", got, note, cycles);
    end
  endtask

  task automatic test_pause();
    int n = 0, strobes = 0, held_bad = 0, sdx, cycles;
    bit got;
    do_reset();
    song = 2'd1; note_done = 1'b1; loop = 1'b0; play = 1'b1;
    for (int c = 0; c < 100 && n < 10; c++) begin
      step();
      if (new_note) n++;
    end
    checks++;
    if (n != 10 || note !== 6'd17) begin
      errors++;
      $display("FAIL pause_10th: got n=%0d note=%0d expected 10 17", n, note);
    end
    step();
    play = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (new_note || song_done) strobes++;
      if (note !== 6'd17) held_bad++;
    end
    checks++;
    if (strobes != 0 || held_bad != 0) begin
      errors++;
      $display("FAIL pause_hold: got strobes=%0d note_changes=%0d expected 0 0", strobes, held_bad);
    end
    play = 1'b1;
    wait_nn(10, got, sdx, cycles);
    checks++;
    if (!got || note !== 6'd18 || cycles != 3) begin
      errors++;
      $display("FAIL pause_resume: got=%b note=%0d lat=%0d expected 1 18 3", got, note, cycles);
    end
    play = 1'b0;
    strobes = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (new_note) strobes++;
    end
    play = 1'b1;
    step();
    checks++;
    if (strobes != 0 || new_note !== 1'b1 || note !== 6'd18) begin
      errors++;
      $display("FAIL pause_emit_refire: got strobes=%0d nn=%b note=%0d expected 0 1 18",
               strobes, new_note, note);
    end
  endtask

  task automatic test_song_change();
    int sd_total = 0, sdx, cycles;
    bit got;
    do_reset();
    song = 2'd2; note_done = 1'b0; loop = 1'b0; play = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_nn(12, got, sdx, cycles);
      checks++;
      if (!got || note !== 6'(16 + k)) begin
        errors++;
        $display("FAIL change_pre[%0d]: got=%b note=%0d expected 1 %0d", k, got, note, 16 + k);
      end
      if (k < 5) begin
        step();
        note_done = 1'b1;
        step();
        note_done = 1'b0;
      end
    end
    step();
    song = 2'd3;
    step();
    if (song_done) sd_total++;
    checks++;
    if (rom_addr !== 7'd96) begin
      errors++;
      $display("FAIL change_addr: got %0d expected 96", rom_addr);
    end
    wait_nn(10, got, sdx, cycles);
    sd_total += sdx;
    checks++;
    if (!got || note !== 6'd24 || sd_total != 0) begin
      errors++;
      $display("FAIL change_restart: got=%b note=%0d song_done=%0d expected 1 24 0", got, note, sd_total);
    end
  endtask

  task automatic test_note_done();
    int extra = 0, nn = 0, sdx, cycles;
    bit got;
    bit sd = 1'b0;
    do_reset();
    song = 2'd2; loop = 1'b1; note_done = 1'b0; play = 1'b1;
    wait_nn(10, got, sdx, cycles);
    checks++;
    if (!got || note !== 6'd16) begin
      errors++;
      $display("FAIL nd_first: got=%b note=%0d expected 1 16", got, note);
    end
    for (int c = 0; c < 30; c++) begin
      step();
      if (new_note) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL nd_wait_hold: got %0d extra new_note expected 0", extra);
    end
    note_done = 1'b1;
    step();
    note_done = 1'b0;
    wait_nn(10, got, sdx, cycles);
    checks++;
    if (!got || note !== 6'd17 || cycles != 2) begin
      errors++;
      $display("FAIL nd_wait_pulse: got=%b note=%0d lat=%0d expected 1 17 2", got, note, cycles);
    end
    note_done = 1'b1;
    step();
    note_done = 1'b0;
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (new_note) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL nd_emit_ignored: got %0d new_note after EMIT pulse expected 0", extra);
    end
    note_done = 1'b1;
    step();
    note_done = 1'b0;
    wait_nn(10, got, sdx, cycles);
    checks++;
    if (!got || note !== 6'd18) begin
      errors++;
      $display("FAIL nd_advance: got=%b note=%0d expected 1 18", got, note);
    end
    note_done = 1'b1;
    for (int c = 0; c < 200; c++) begin
      step();
      if (new_note) nn++;
      if (song_done) begin
        sd = 1'b1;
        break;
      end
    end
    checks++;
    if (!sd || nn != 29) begin
      errors++;
      $display("FAIL nd_song_end: got song_done=%b notes=%0d expected 1 29", sd, nn);
    end
    wait_nn(10, got, sdx, cycles);
    checks++;
    if (!got || note !== 6'd16 || cycles != 3) begin
      errors++;
      $display("FAIL nd_wrap: got=%b note=%0d lat=%0d expected 1 16 3", got, note, cycles);
    end
    note_done = 1'b0;
  endtask

`ifdef SONG_SEQ_EOS_MARKER_EN
  task automatic test_eos();
    int nn = 0, sd = 0;
    do_reset();
    song = 2'd1; note_done = 1'b1; loop = 1'b0; play = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step();
      if (new_note) nn++;
      if (song_done) sd++;
    end
    checks++;
    if (nn != 7 || sd != 1) begin
      errors++;
      $display("FAIL eos_count: got notes=%0d song_done=%0d expected 7 1", nn, sd);
    end
    checks++;
    if (note !== 6'd14 || duration !== 6'd7) begin
      errors++;
      $display("FAIL eos_hold: got note=%0d dur=%0d expected 14 7", note, duration);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_song();
    test_pause();
    test_song_change();
    test_note_done();
`ifdef SONG_SEQ_EOS_MARKER_EN
    test_eos();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
